pwm_config_validator_multi: RTL

Multi-channel, dead-time-aware successor to the single half-bridge timing validator.
- Accepts a staged timing set: one shared period plus four edge ticks per half-bridge channel.
- Checks the channels sequentially, one per cycle.
- On success, applies the whole set atomically at the next PWM period boundary.
- Sits between the host register interface and the PWM counter/comparator blocks, so they only ever see validated configurations.

---
 rtl/pwm_validator_pkg.sv | 19 +
 rtl/pwm_channel_check.sv | 43 ++++
 rtl/pwm_config_validator_multi.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pwm_validator_pkg.sv
// Shared constants for the multi-channel PWM configuration validator:
// rejection reason codes and the controller state encoding.
package pwm_validator_pkg;

    localparam logic [2:0] ERR_NONE                  = 3'd0;
    localparam logic [2:0] ERR_PERIOD_ZERO           = 3'd1;
    localparam logic [2:0] ERR_HIGHSIDE_ORDER        = 3'd2;
    localparam logic [2:0] ERR_DEADTIME_HIGH_LOW     = 3'd3;
    localparam logic [2:0] ERR_LOWSIDE_ORDER         = 3'd4;
    localparam logic [2:0] ERR_LOWSIDE_BEYOND_PERIOD = 3'd5;
    localparam logic [2:0] ERR_DEADTIME_WRAP         = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_channel_check.sv
// Combinational timing check of one half-bridge channel against the period.
// All arithmetic is one bit wider than the ticks so nothing can wrap.
module pwm_channel_check
    import pwm_validator_pkg::*;
#(
    parameter int bitwidth      = 8,
    parameter int dead_time_min = 1
) (
    input  logic [bitwidth-1:0]   period_i,
    input  logic [4*bitwidth-1:0] edges_i,
    output logic                  pass_o,
    output logic [2:0]            code_o
);

    logic [bitwidth:0] per, rh, fh, rl, fl, dt;

    assign per = {1'b0, period_i};
    assign rh  = {1'b0, edges_i[0*bitwidth +: bitwidth]};
    assign fh  = {1'b0, edges_i[1*bitwidth +: bitwidth]};
    assign rl  = {1'b0, edges_i[2*bitwidth +: bitwidth]};
    assign fl  = {1'b0, edges_i[3*bitwidth +: bitwidth]};
    assign dt  = (bitwidth+1)'(dead_time_min);

    // Priority order matters: the first failing rule names the rejection.
    always_comb begin
        code_o = ERR_NONE;
        if (per == '0)
            code_o = ERR_PERIOD_ZERO;
        else if (rh >= fh)
            code_o = ERR_HIGHSIDE_ORDER;
        else if (fh + dt > rl)
            code_o = ERR_DEADTIME_HIGH_LOW;
        else if (rl >= fl)
            code_o = ERR_LOWSIDE_ORDER;
        else if (fl > per)
            code_o = ERR_LOWSIDE_BEYOND_PERIOD;
        else if ((per - fl) + rh < dt)
            code_o = ERR_DEADTIME_WRAP;
    end

    assign pass_o = (code_o == ERR_NONE);

endmodule

// File: rtl/pwm_config_validator_multi.sv
// Stages a multi-channel PWM timing set, checks one channel per cycle and
// applies the whole set atomically at the next period boundary.
module pwm_config_validator_multi
    import pwm_validator_pkg::*;
#(
    parameter int bitwidth      = 8,
    parameter int channel_count = 3,
    parameter int dead_time_min = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [bitwidth-1:0]                 period_in,
    input  logic [4*bitwidth*channel_count-1:0] edges_in,
    input  logic                                load,
    input  logic                                period_end,
    output logic                                ready,
    output logic [bitwidth-1:0]                 period_out,
    output logic [4*bitwidth*channel_count-1:0] edges_out,
    output logic                                configuration_valid,
    output logic                                update_pulse,
    output logic                                error,
    output logic [((channel_count > 1) ? $clog2(channel_count) : 1)-1:0] error_channel,
    output logic [2:0]                          error_code
);

    localparam int EW = 4 * bitwidth;
    localparam int AW = EW * channel_count;
    localparam int CW = (channel_count > 1) ? $clog2(channel_count) : 1;
    localparam logic [CW-1:0] LAST = CW'(channel_count - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [bitwidth-1:0] stg_per_q, stg_per_d;
    logic [AW-1:0]       stg_edg_q, stg_edg_d;
    logic [bitwidth-1:0] per_q, per_d;
    logic [AW-1:0]       edg_q, edg_d;
    logic                valid_q, valid_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;
    logic [CW-1:0]       ech_q, ech_d;
    logic [2:0]          ecode_q, ecode_d;

    logic [EW-1:0]       ch_sel;
    logic                ch_pass;
    logic [2:0]          ch_code;

    assign ch_sel = stg_edg_q[int'(idx_q) * EW +: EW];

    pwm_channel_check #(
        .bitwidth      (bitwidth),
        .dead_time_min (dead_time_min)
    ) u_check (
        .period_i (stg_per_q),
        .edges_i  (ch_sel),
        .pass_o   (ch_pass),
        .code_o   (ch_code)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            stg_per_q <= '0;
            stg_edg_q <= '0;
            per_q     <= '0;
            edg_q     <= '0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            ech_q     <= '0;
            ecode_q   <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stg_per_q <= stg_per_d;
            stg_edg_q <= stg_edg_d;
            per_q     <= per_d;
            edg_q     <= edg_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
            ech_q     <= ech_d;
            ecode_q   <= ecode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stg_per_d = stg_per_q;
        stg_edg_d = stg_edg_q;
        per_d     = per_q;
        edg_d     = edg_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        err_d     = err_q;
        ech_d     = ech_q;
        ecode_d   = ecode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    stg_per_d = period_in;
                    stg_edg_d = edges_in;
                    err_d     = 1'b0;
                    ech_d     = '0;
                    ecode_d   = ERR_NONE;
                    idx_d     = '0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!ch_pass) begin
                    err_d   = 1'b1;
                    ech_d   = idx_q;
                    ecode_d = ch_code;
                    state_d = ST_IDLE;
                end else if (idx_q == LAST) begin
                    state_d = ST_ARMED;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_ARMED: begin
                if (period_end) begin
                    per_d   = stg_per_q;
                    edg_d   = stg_edg_q;
                    valid_d = 1'b1;
                    upd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready               = (state_q == ST_IDLE);
    assign period_out          = per_q;
    assign edges_out           = edg_q;
    assign configuration_valid = valid_q;
    assign update_pulse        = upd_q;
    assign error               = err_q;
    assign error_channel       = ech_q;
    assign error_code          = ecode_q;

endmodule
